// File: rtl/output_pkt_arbiter_pkg.sv
// Shared definitions for the output packet arbiter.
//   - FSM state encoding
//   - arb_status bit positions
//   - app_mode codes and the decode that produces the arbiter enable
package output_pkt_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  localparam int unsigned ST_BUSY      = 7;
  localparam int unsigned ST_ERR       = 6;
  localparam int unsigned ST_GRANT_LSB = 4;

  typedef enum logic [1:0] {
    APP_MODE_OFF    = 2'd0,
    APP_MODE_STREAM = 2'd1,
    APP_MODE_REPLY  = 2'd2,
    APP_MODE_DIAG   = 2'd3
  } app_mode_e;

  // Any mode other than OFF produces traffic towards the output FIFO.
  function automatic logic app_mode_arb_en(app_mode_e mode);
    return mode != APP_MODE_OFF;
  endfunction

endpackage

// File: rtl/output_pkt_arbiter_if.sv
// Bundle of the source-side and output-FIFO-side signals of the arbiter.
//   src_data/src_valid/src_last : packet sources (source i at [i*DW +: DW])
//   src_rd                      : per-source pop strobe
//   dout/wr_en/full             : output FIFO write port
//   pkt_end                     : present only when OUTPUT_ARB_PKT_END_EN is defined
// Modports: master = arbiter side, slave = sources + FIFO side.
interface output_pkt_arbiter_if #(
  parameter int unsigned N_SRC = 2,
  parameter int unsigned DW    = 16
);

  logic [N_SRC*DW-1:0] src_data;
  logic [N_SRC-1:0]    src_valid;
  logic [N_SRC-1:0]    src_last;
  logic [N_SRC-1:0]    src_rd;
  logic [DW-1:0]       dout;
  logic                wr_en;
  logic                full;
`ifdef OUTPUT_ARB_PKT_END_EN
  logic                pkt_end;
`endif

  modport master (
    input  src_data, src_valid, src_last, full,
    output src_rd, dout, wr_en
`ifdef OUTPUT_ARB_PKT_END_EN
    , output pkt_end
`endif
  );

  modport slave (
    output src_data, src_valid, src_last, full,
    input  src_rd, dout, wr_en
`ifdef OUTPUT_ARB_PKT_END_EN
    , input pkt_end
`endif
  );

endinterface

// File: rtl/output_pkt_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req  : request vector
//   last : index of the most recently served requester
//   idx  : first requester found scanning last+1, last+2, ... (mod N_SRC)
//   any  : at least one request present (idx is 0 otherwise)
module output_pkt_arbiter_rr_pick #(
  parameter  int unsigned N_SRC = 2,
  localparam int unsigned IdxW  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IdxW-1:0]  last,
  output logic [IdxW-1:0]  idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    // k = N_SRC revisits 'last' itself, so a lone requester is always found.
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      if (!any && req[(32'(last) + k) % N_SRC]) begin
        any = 1'b1;
        idx = IdxW'((32'(last) + k) % N_SRC);
      end
    end
  end

endmodule

// File: rtl/output_pkt_arbiter.sv
// Output packet arbiter: shares one output FIFO write port between N_SRC packet
// sources. Packets are atomic, grants rotate round-robin at packet boundaries,
// and a packet reaching MAX_PKT_WORDS words is force-terminated (sticky err).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : arbitration enable, only sampled between packets
//   bus         : output_pkt_arbiter_if.master (sources + output FIFO)
//   arb_status  : [7] busy, [6] err sticky, [5:4] grant idx, [3:0] zero
// Build option: define OUTPUT_ARB_PKT_END_EN to add bus.pkt_end, which marks the
// final word of each packet (src_last or forced end). Arbitration is identical.
module output_pkt_arbiter
  import output_pkt_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC         = 2,
  parameter int unsigned DW            = 16,
  parameter int unsigned MAX_PKT_WORDS = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  output_pkt_arbiter_if.master     bus,
  output logic [7:0]               arb_status
);

  localparam int unsigned IdxW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned CntW = $clog2(MAX_PKT_WORDS);

  arb_state_e      state_q;
  logic [IdxW-1:0] grant_q, rr_ptr_q, pick_idx;
  logic [CntW-1:0] word_cnt_q;
  logic            err_q;
  logic            pick_any, xfer, cnt_max, pkt_done;

  output_pkt_arbiter_rr_pick #(
    .N_SRC (N_SRC)
  ) u_rr_pick (
    .req  (bus.src_valid),
    .last (rr_ptr_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign xfer     = (state_q == ARB_XFER) & bus.src_valid[grant_q] & ~bus.full;
  assign cnt_max  = (word_cnt_q == CntW'(MAX_PKT_WORDS - 1));
  assign pkt_done = xfer & (bus.src_last[grant_q] | cnt_max);

  // Zero-latency output mux; dout is forced to 0 whenever nothing is written.
  always_comb begin
    bus.src_rd = '0;
    bus.dout   = '0;
    if (xfer) begin
      bus.src_rd[grant_q] = 1'b1;
      bus.dout            = bus.src_data[grant_q*DW +: DW];
    end
  end

  assign bus.wr_en = xfer;
`ifdef OUTPUT_ARB_PKT_END_EN
  assign bus.pkt_end = pkt_done;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= IdxW'(N_SRC - 1);  // source 0 wins the first arbitration
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (en && pick_any) begin
            grant_q <= pick_idx;
            state_q <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          if (pkt_done) begin
            rr_ptr_q   <= grant_q;
            word_cnt_q <= '0;
            state_q    <= ARB_IDLE;
            if (!bus.src_last[grant_q]) err_q <= 1'b1;
          end else if (xfer) begin
            word_cnt_q <= word_cnt_q + CntW'(1);
          end
        end
      endcase
    end
  end

  // Status is a straight concatenation of flops.
  always_comb begin
    arb_status                      = '0;
    arb_status[ST_BUSY]             = (state_q == ARB_XFER);
    arb_status[ST_ERR]              = err_q;
    arb_status[ST_GRANT_LSB +: 2]   = 2'(grant_q);
  end

endmodule

// File: tb/tb_output_pkt_arbiter.sv
module tb_output_pkt_arbiter;

  localparam int unsigned NSrc = 2;
  localparam int unsigned Dw   = 16;
  localparam int unsigned MaxW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [7:0] arb_status;

  output_pkt_arbiter_if #(.N_SRC(NSrc), .DW(Dw)) bus ();

  output_pkt_arbiter #(
    .N_SRC         (NSrc),
    .DW            (Dw),
    .MAX_PKT_WORDS (MaxW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .bus        (bus),
    .arb_status (arb_status)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Source queues: bit 16 = last flag, [15:0] = data.
  logic [16:0] q0[$];
  logic [16:0] q1[$];

  logic        s_wr, s_pe;
  logic [1:0]  s_rd;
  logic [15:0] s_dout;
  logic [7:0]  s_st;

  task automatic drive();
    bus.src_valid[0]    = (q0.size() != 0);
    bus.src_last[0]     = (q0.size() != 0) ? q0[0][16] : 1'b0;
    bus.src_data[15:0]  = (q0.size() != 0) ? q0[0][15:0] : 16'h0;
    bus.src_valid[1]    = (q1.size() != 0);
    bus.src_last[1]     = (q1.size() != 0) ? q1[0][16] : 1'b0;
    bus.src_data[31:16] = (q1.size() != 0) ? q1[0][15:0] : 16'h0;
  endtask

  // One clock: sample at negedge, then pop consumed words after the posedge.
  task automatic step();
    @(negedge clk);
    s_wr   = bus.wr_en;
    s_rd   = bus.src_rd;
    s_dout = bus.dout;
    s_st   = arb_status;
`ifdef OUTPUT_ARB_PKT_END_EN
    s_pe   = bus.pkt_end;
`else
    s_pe   = 1'b0;
`endif
    @(posedge clk);
    #1;
    if (s_rd[0] && q0.size() != 0) void'(q0.pop_front());
    if (s_rd[1] && q1.size() != 0) void'(q1.pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    en       = 1'b0;
    bus.full = 1'b0;
    q0.delete();
    q1.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.full = 1'b0;
    en       = 1'b1;
    q0.push_back(17'h1_AAAA);
    drive();
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++;
      if ({bus.wr_en, bus.src_rd, bus.dout, arb_status} !== 27'h0) begin
        n_err++;
        $display("FAIL reset cyc%0d: got wr=%b rd=%b dout=%h st=%h, want all 0",
                 i, bus.wr_en, bus.src_rd, bus.dout, arb_status);
      end
    end
    do_reset();
  endtask

  task automatic test_single();
    logic        ew [5] = '{0, 1, 1, 1, 0};
    logic [1:0]  er [5] = '{0, 1, 1, 1, 0};
    logic [15:0] ed [5] = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h0};
    logic [7:0]  es [5] = '{8'h00, 8'h80, 8'h80, 8'h80, 8'h00};
    logic        ep [5] = '{0, 0, 0, 1, 0};
    q0.push_back(17'h0_0001);
    q0.push_back(17'h0_0002);
    q0.push_back(17'h1_0003);
    en = 1'b1;
    drive();
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if ({s_wr, s_rd, s_dout, s_st} !== {ew[i], er[i], ed[i], es[i]}) begin
        n_err++;
        $display("FAIL single cyc%0d: got wr=%b rd=%b dout=%h st=%h, want wr=%b rd=%b dout=%h st=%h",
                 i, s_wr, s_rd, s_dout, s_st, ew[i], er[i], ed[i], es[i]);
      end
`ifdef OUTPUT_ARB_PKT_END_EN
      n_vec++;
      if (s_pe !== ep[i]) begin
        n_err++;
        $display("FAIL single_pkt_end cyc%0d: got %b want %b", i, s_pe, ep[i]);
      end
`endif
    end
  endtask

  task automatic test_round_robin();
    logic        ew [13] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
    logic [1:0]  er [13] = '{0, 1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2, 0};
    logic [15:0] ed [13] = '{16'h0, 16'h1000, 16'h1001, 16'h0, 16'h2000, 16'h2001, 16'h0,
                             16'h1002, 16'h1003, 16'h0, 16'h2002, 16'h2003, 16'h0};
    logic [7:0]  es [13] = '{8'h00, 8'h80, 8'h80, 8'h00, 8'h90, 8'h90, 8'h10,
                             8'h80, 8'h80, 8'h00, 8'h90, 8'h90, 8'h10};
    logic        ep [13] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    do_reset();
    q0.push_back(17'h0_1000); q0.push_back(17'h1_1001);
    q0.push_back(17'h0_1002); q0.push_back(17'h1_1003);
    q1.push_back(17'h0_2000); q1.push_back(17'h1_2001);
    q1.push_back(17'h0_2002); q1.push_back(17'h1_2003);
    en = 1'b1;
    drive();
    for (int i = 0; i < 13; i++) begin
      step();
      n_vec++;
      if ({s_wr, s_rd, s_dout, s_st} !== {ew[i], er[i], ed[i], es[i]}) begin
        n_err++;
        $display("FAIL round_robin cyc%0d: got wr=%b rd=%b dout=%h st=%h, want wr=%b rd=%b dout=%h st=%h",
                 i, s_wr, s_rd, s_dout, s_st, ew[i], er[i], ed[i], es[i]);
      end
`ifdef OUTPUT_ARB_PKT_END_EN
      n_vec++;
      if (s_pe !== ep[i]) begin
        n_err++;
        $display("FAIL rr_pkt_end cyc%0d: got %b want %b", i, s_pe, ep[i]);
      end
`endif
    end
  endtask

  task automatic test_full_stall();
    logic        ef [9] = '{0, 0, 1, 1, 1, 1, 0, 0, 0};
    logic        ew [9] = '{0, 1, 0, 0, 0, 0, 1, 1, 0};
    logic [1:0]  er [9] = '{0, 2, 0, 0, 0, 0, 2, 2, 0};
    logic [15:0] ed [9] = '{16'h0, 16'hBEE0, 16'h0, 16'h0, 16'h0, 16'h0,
                            16'hBEEF, 16'hBEF0, 16'h0};
    logic [7:0]  es [9] = '{8'h00, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h10};
    do_reset();
    q1.push_back(17'h0_BEE0);
    q1.push_back(17'h0_BEEF);
    q1.push_back(17'h1_BEF0);
    en = 1'b1;
    drive();
    for (int i = 0; i < 9; i++) begin
      bus.full = ef[i];
      step();
      n_vec++;
      if ({s_wr, s_rd, s_dout, s_st} !== {ew[i], er[i], ed[i], es[i]}) begin
        n_err++;
        $display("FAIL full_stall cyc%0d: got wr=%b rd=%b dout=%h st=%h, want wr=%b rd=%b dout=%h st=%h",
                 i, s_wr, s_rd, s_dout, s_st, ew[i], er[i], ed[i], es[i]);
      end
    end
    bus.full = 1'b0;
  endtask

  task automatic test_forced_end();
    logic        ew [13] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 1};
    logic [1:0]  er [13] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 2, 0, 1};
    logic [15:0] ed [13] = '{16'h0, 16'h4000, 16'h4001, 16'h4002, 16'h4003, 16'h4004,
                             16'h4005, 16'h4006, 16'h4007, 16'h0, 16'h5000, 16'h0, 16'h4008};
    logic [7:0]  es [13] = '{8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80,
                             8'h80, 8'h40, 8'hD0, 8'h50, 8'hC0};
    logic        ep [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
    do_reset();
    for (int w = 0; w < 10; w++) q0.push_back(17'h0_4000 + 17'(w));
    q1.push_back(17'h1_5000);
    en = 1'b1;
    drive();
    for (int i = 0; i < 13; i++) begin
      step();
      n_vec++;
      if ({s_wr, s_rd, s_dout, s_st} !== {ew[i], er[i], ed[i], es[i]}) begin
        n_err++;
        $display("FAIL forced_end cyc%0d: got wr=%b rd=%b dout=%h st=%h, want wr=%b rd=%b dout=%h st=%h",
                 i, s_wr, s_rd, s_dout, s_st, ew[i], er[i], ed[i], es[i]);
      end
`ifdef OUTPUT_ARB_PKT_END_EN
      n_vec++;
      if (s_pe !== ep[i]) begin
        n_err++;
        $display("FAIL forced_pkt_end cyc%0d: got %b want %b", i, s_pe, ep[i]);
      end
`endif
    end
  endtask

  task automatic test_en_drop_and_reset();
    logic        ee [12] = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    logic        ew [12] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1};
    logic [1:0]  er [12] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 2, 0, 1};
    logic [15:0] ed [12] = '{16'h0, 16'h6000, 16'h6001, 16'h6002, 16'h6003, 16'h0,
                             16'h0, 16'h0, 16'h0, 16'h7000, 16'h0, 16'h8000};
    logic [7:0]  es [12] = '{8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00,
                             8'h00, 8'h90, 8'h10, 8'h80};
    logic        pe_now;
    do_reset();
    q0.push_back(17'h0_6000); q0.push_back(17'h0_6001);
    q0.push_back(17'h0_6002); q0.push_back(17'h1_6003);
    q0.push_back(17'h0_8000); q0.push_back(17'h0_8001); q0.push_back(17'h1_8002);
    q1.push_back(17'h1_7000);
    drive();
    for (int i = 0; i < 12; i++) begin
      en = ee[i];
      step();
      n_vec++;
      if ({s_wr, s_rd, s_dout, s_st} !== {ew[i], er[i], ed[i], es[i]}) begin
        n_err++;
        $display("FAIL en_drop cyc%0d: got wr=%b rd=%b dout=%h st=%h, want wr=%b rd=%b dout=%h st=%h",
                 i, s_wr, s_rd, s_dout, s_st, ew[i], er[i], ed[i], es[i]);
      end
    end
    // Mid-packet (0x8001 pending): async reset must clear outputs at once.
    rst_n = 1'b0;
    #1;
`ifdef OUTPUT_ARB_PKT_END_EN
    pe_now = bus.pkt_end;
`else
    pe_now = 1'b0;
`endif
    n_vec++;
    if ({bus.wr_en, bus.src_rd, bus.dout, arb_status, pe_now} !== 28'h0) begin
      n_err++;
      $display("FAIL async_reset: got wr=%b rd=%b dout=%h st=%h pe=%b, want all 0",
               bus.wr_en, bus.src_rd, bus.dout, arb_status, pe_now);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
    $fatal(1);
  end

  initial begin
    bus.full = 1'b0;
    drive();
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_forced_end();
    test_en_drop_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
